// File: rtl/tmp_pkg.sv
// Shared types and default parameters for the temperature-sensor decimator.
package tmp_pkg;

  localparam int unsigned OSR_LOG2_DEF = 8;
  localparam int unsigned SETTLE_DEF   = 4;
  localparam int unsigned SETTLE_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2
  } state_t;

endpackage

// File: rtl/tmp_result_hold.sv
// Single-entry valid/ready holding register for finished conversion codes.
module tmp_result_hold #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] code_in,
  input  logic         ready,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         drop
);

  logic take;

  // A new result is taken when the slot is empty or is being drained this cycle.
  assign take = load && (!valid || ready);
  assign drop = load && valid && !ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code  <= '0;
      valid <= 1'b0;
    end else if (take) begin
      code  <= code_in;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tmp_decimator.sv
// Counts comparator ones over 2^OSR_LOG2 samples after a settle period.
module tmp_decimator #(
  parameter int unsigned OSR_LOG2 = tmp_pkg::OSR_LOG2_DEF,
  parameter int unsigned SETTLE   = tmp_pkg::SETTLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sample,
  input  logic              cmp,
  output logic [OSR_LOG2:0] code,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              overrun
);

  import tmp_pkg::state_t;
  import tmp_pkg::IDLE;
  import tmp_pkg::ACCUM;

  localparam int unsigned NW = OSR_LOG2;
  localparam int unsigned CW = OSR_LOG2 + 1;
  localparam int unsigned SW = tmp_pkg::SETTLE_CNT_W;

  state_t        state, state_next;
  logic [SW-1:0] settle_cnt, settle_next;
  logic [NW-1:0] n, n_next;
  logic [CW-1:0] ones, ones_next;
  logic [CW-1:0] final_c;
  logic          load_c;
  logic          start_c;
  logic          drop;

  assign final_c = ones + CW'(cmp);

  // Next-state and counter update.
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    n_next      = n;
    ones_next   = ones;
    load_c      = 1'b0;
    start_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          start_c     = 1'b1;
          settle_next = '0;
          n_next      = '0;
          ones_next   = '0;
          state_next  = (SETTLE == 0) ? ACCUM : tmp_pkg::SETTLE;
        end
      end
      tmp_pkg::SETTLE: begin
        if (!en) begin
          state_next = IDLE;
        end else if (sample) begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            state_next  = ACCUM;
            settle_next = '0;
            n_next      = '0;
            ones_next   = '0;
          end else begin
            settle_next = settle_cnt + SW'(1);
          end
        end
      end
      ACCUM: begin
        if (!en) begin
          state_next = IDLE;
        end else if (sample) begin
          if (&n) begin
            load_c    = 1'b1;
            n_next    = '0;
            ones_next = '0;
          end else begin
            n_next    = n + NW'(1);
            ones_next = final_c;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      n          <= '0;
      ones       <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      n          <= n_next;
      ones       <= ones_next;
      busy       <= (state_next != IDLE);
      // Sticky until the next enable starts a fresh conversion run.
      overrun    <= (overrun && !start_c) || drop;
    end
  end

  tmp_result_hold #(.W(CW)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load    (load_c),
    .code_in (final_c),
    .ready   (ready),
    .code    (code),
    .valid   (valid),
    .drop    (drop)
  );

endmodule

// File: tb/tb_tmp_decimator.sv
// Directed bench for tmp_decimator (OSR_LOG2=4, SETTLE=2) against a sample-count model.
module tb_tmp_decimator;

  localparam int OSR = 4;
  localparam int SET = 2;
  localparam int WIN = 16;
  localparam int CW  = OSR + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          sample = 1'b0;
  logic          cmp = 1'b0;
  logic          ready = 1'b0;
  logic [CW-1:0] code;
  logic          valid;
  logic          busy;
  logic          overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tmp_decimator #(.OSR_LOG2(OSR), .SETTLE(SET)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sample  (sample),
    .cmp     (cmp),
    .code    (code),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy),
    .overrun (overrun)
  );

  // Model: count samples since enable; the window position is derived arithmetically.
  bit m_active = 1'b0;
  int m_cnt = 0;
  int m_wsum = 0;
  bit m_valid = 1'b0;
  int m_code = 0;
  bit m_ovr = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    bit have;
    int res;
    if (!reset) begin
      m_active = 1'b0;
      m_cnt    = 0;
      m_wsum   = 0;
      m_valid  = 1'b0;
      m_code   = 0;
      m_ovr    = 1'b0;
    end else begin
      have = 1'b0;
      res  = 0;
      if (!m_active) begin
        if (en) begin
          m_active = 1'b1;
          m_cnt    = 0;
          m_wsum   = 0;
          m_ovr    = 1'b0;
        end
      end else if (!en) begin
        m_active = 1'b0;
      end else if (sample) begin
        if (m_cnt >= SET) begin
          m_wsum = m_wsum + int'(cmp);
          if ((m_cnt - SET) % WIN == WIN - 1) begin
            have   = 1'b1;
            res    = m_wsum;
            m_wsum = 0;
          end
        end
        m_cnt = m_cnt + 1;
      end
      if (have) begin
        if (!m_valid || ready) begin
          m_valid = 1'b1;
          m_code  = res;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("model_code", 32'(code), 32'(m_code));
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_busy", 32'(busy), 32'(m_active));
      chk("model_overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic cyc(input logic e, input logic s, input logic c, input logic r);
    en = e;
    sample = s;
    cmp = c;
    ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code", 32'(code), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    reset = 1'b1;

    // 18 all-one samples, ready held: first two settle, then code 16.
    cyc(1, 0, 0, 1);
    chk("a_busy_start", 32'(busy), 1);
    for (int i = 0; i < 17; i++) cyc(1, 1, 1, 1);
    chk("a_valid_before", 32'(valid), 0);
    cyc(1, 1, 1, 1);
    chk("a_valid", 32'(valid), 1);
    chk("a_code", 32'(code), 16);
    cyc(1, 0, 0, 1);
    chk("a_valid_drained", 32'(valid), 0);
    cyc(0, 0, 0, 1);
    chk("a_busy_off", 32'(busy), 0);

    // Alternating 1,0 with 0-3 idle cycles between strobes -> 8.
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      repeat (i % 4) cyc(1, 0, 0, 0);
      cyc(1, 1, (i % 2) == 0, 0);
    end
    chk("b_valid", 32'(valid), 1);
    chk("b_code", 32'(code), 8);
    cyc(1, 0, 0, 1);
    chk("b_valid_drained", 32'(valid), 0);

    // Two windows with ready low: second (all ones) is dropped.
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0);
    chk("c_valid_w1", 32'(valid), 1);
    chk("c_code_w1", 32'(code), 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 0);
    chk("c_code_held", 32'(code), 0);
    chk("c_valid_held", 32'(valid), 1);
    chk("c_overrun", 32'(overrun), 1);
    cyc(1, 0, 0, 1);
    chk("c_valid_drained", 32'(valid), 0);

    // Drop en mid-window, re-raise: re-settle and count only new samples.
    for (int i = 0; i < 9; i++) cyc(1, 1, 1, 1);
    cyc(0, 1, 1, 1);
    chk("d_busy_off", 32'(busy), 0);
    chk("d_overrun_kept", 32'(overrun), 1);
    cyc(1, 0, 0, 0);
    chk("d_overrun_clr", 32'(overrun), 0);
    chk("d_busy_on", 32'(busy), 1);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, i < 5, 0);
    chk("d_valid", 32'(valid), 1);
    chk("d_code", 32'(code), 5);

    // Asynchronous reset mid-window with a pending result.
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("e_valid", 32'(valid), 0);
    chk("e_code", 32'(code), 0);
    chk("e_busy", 32'(busy), 0);
    chk("e_overrun", 32'(overrun), 0);
    en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    chk("e_idle", 32'(busy), 0);

    // Window end coincides with acceptance of the previous result.
    cyc(1, 0, 0, 0);
    chk("f_busy_first_edge", 32'(busy), 1);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 0);
    chk("f_code_prev", 32'(code), 16);
    for (int i = 0; i < 15; i++) cyc(1, 1, i < 3, 0);
    cyc(1, 1, 0, 1);
    chk("f_valid", 32'(valid), 1);
    chk("f_code", 32'(code), 3);
    chk("f_overrun", 32'(overrun), 0);
    cyc(1, 0, 0, 1);
    chk("f_valid_drained", 32'(valid), 0);
    cyc(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
